bubble_sort_ctrl: RTL

- Sequencer that sorts, in place and ascending unsigned, the SIZE=2**ADDR_WIDTH words held in the team's dual-port RAM (2 async read ports, 1 sync write port).
- Runs after the ROM-to-RAM copy phase, triggered by start/finish handshake from the top-level flow FSM.
- Drives all RAM address/write lines; RAM is instantiated by the parent, not inside this block.

---
 rtl/bubble_sort_ctrl_pkg.sv | 11 +
 rtl/bubble_sort_ctrl.sv | 89 ++++++++
 2 files changed

// File: rtl/bubble_sort_ctrl_pkg.sv
// bubble_sort_ctrl_pkg: state encodings shared by the sort sequencer and the flow FSM debug displays
package bubble_sort_ctrl_pkg;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    COMPARE  = 3'd1,
    SWAP_LO  = 3'd2,
    SWAP_HI  = 3'd3,
    PASS_END = 3'd4,
    DONE     = 3'd5
  } state_t;
endpackage

// File: rtl/bubble_sort_ctrl.sv
// bubble_sort_ctrl: in-place ascending unsigned bubble sort over an external 2R/1W RAM
module bubble_sort_ctrl
  import bubble_sort_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 2,
  parameter int DATA_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  output logic                    busy,
  output logic                    finish,
  output logic [2*ADDR_WIDTH-1:0] swap_count,
  output logic [ADDR_WIDTH-1:0]   ram_read_addr_1,
  output logic [ADDR_WIDTH-1:0]   ram_read_addr_2,
  input  logic [DATA_WIDTH-1:0]   ram_read_data_1,
  input  logic [DATA_WIDTH-1:0]   ram_read_data_2,
  output logic                    ram_we,
  output logic [ADDR_WIDTH-1:0]   ram_write_addr,
  output logic [DATA_WIDTH-1:0]   ram_write_data
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(2**ADDR_WIDTH - 2);
  state_t                  r_state;
  logic [ADDR_WIDTH-1:0]   r_p;
  logic [ADDR_WIDTH-1:0]   r_i;
  logic                    r_swapped;
  logic [DATA_WIDTH-1:0]   r_hold;
  logic [2*ADDR_WIDTH-1:0] r_swap_count;
  logic                    w_last_i;
  logic                    w_act;
  logic [ADDR_WIDTH-1:0]   w_i_next;
  assign w_last_i = r_i == LAST - r_p;
  assign w_i_next = r_i + 1'b1;
  assign w_act    = r_state inside {COMPARE, SWAP_LO, SWAP_HI};
  // Outputs are pure decodes of registered state so start never reaches them combinationally
  assign busy            = r_state != IDLE;
  assign finish          = r_state == DONE;
  assign swap_count      = r_swap_count;
  assign ram_we          = r_state inside {SWAP_LO, SWAP_HI};
  assign ram_read_addr_1 = w_act ? r_i : '0;
  assign ram_read_addr_2 = w_act ? w_i_next : '0;
  assign ram_write_addr  = r_state == SWAP_LO ? r_i : r_state == SWAP_HI ? w_i_next : '0;
  assign ram_write_data  = r_state == SWAP_LO ? ram_read_data_2 : r_state == SWAP_HI ? r_hold : '0;
  // Sort sequencer: one compare per cycle, a swap is two writes with the larger word parked in hold
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_p          <= '0;
      r_i          <= '0;
      r_swapped    <= 1'b0;
      r_hold       <= '0;
      r_swap_count <= '0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_state      <= COMPARE;
          r_p          <= '0;
          r_i          <= '0;
          r_swapped    <= 1'b0;
          r_swap_count <= '0;
        end
        COMPARE: if (ram_read_data_1 > ram_read_data_2) begin
          r_hold  <= ram_read_data_1;
          r_state <= SWAP_LO;
        end else if (w_last_i) r_state <= PASS_END;
        else r_i <= w_i_next;
        SWAP_LO: r_state <= SWAP_HI;
        SWAP_HI: begin
          r_swapped    <= 1'b1;
          r_swap_count <= r_swap_count + 1'b1;
          if (w_last_i) r_state <= PASS_END;
          else begin
            r_i     <= w_i_next;
            r_state <= COMPARE;
          end
        end
        PASS_END: if (!r_swapped || r_p == LAST) r_state <= DONE;
        else begin
          r_p       <= r_p + 1'b1;
          r_i       <= '0;
          r_swapped <= 1'b0;
          r_state   <= COMPARE;
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
